// File: rtl/mem_pkg.sv
// Shared types for the data-memory request path.
// Holds the access-size encoding seen on req_size, the request-controller
// state encoding, and the memory word width.
package mem_pkg;

    localparam int WORD_W = 32;

    // Encoding of req_size. 2'b11 is not a member and is always an error.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        WR     = 3'd4,
        RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the data-memory request controller.
//
// Ports:
//   chk_size, chk_lane  size and addr[1:0] of the request being offered
//   chk_error           illegal size or misaligned address for that request
//   size, lane          size and addr[1:0] of the request in flight
//   is_unsigned         zero-extend (1) or sign-extend (0) load data
//   rd_word             word returned by the memory
//   wr_data             right-aligned store data
//   ld_data             extracted and extended load result
//   st_word             rd_word with the addressed byte/half replaced
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]        chk_size,
    input  logic [1:0]        chk_lane,
    output logic              chk_error,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] ld_data,
    output logic [WORD_W-1:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        chk_error = 1'b0;
        case (chk_size)
            SZ_BYTE: chk_error = 1'b0;
            SZ_HALF: chk_error = chk_lane[0];
            SZ_WORD: chk_error = |chk_lane;
            default: chk_error = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        byte_sign = ~is_unsigned & byte_sel[7];
        half_sign = ~is_unsigned & half_sel[15];

        ld_data = rd_word;
        case (size)
            SZ_BYTE: ld_data = {{24{byte_sign}}, byte_sel};
            SZ_HALF: ld_data = {{16{half_sign}}, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        st_word = rd_word;
        case (size)
            SZ_BYTE: st_word[{lane, 3'b000} +: 8] = wr_data[7:0];
            SZ_HALF: begin
                if (lane[1]) st_word[31:16] = wr_data[15:0];
                else         st_word[15:0]  = wr_data[15:0];
            end
            default: st_word = wr_data;
        endcase
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Initiator-side controller between the MEM stage and a word-wide data
// memory without byte enables. Sub-word stores become read-modify-write.
// One request in flight at a time; all outputs are registered.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_*                pipeline request (valid/ready handshake)
//   resp_valid/rdata/error  one-cycle completion pulse with load data / error
//   mem_read_enable/addr    read request, held until mem_ready
//   mem_write_enable/addr/data  single-cycle write
//   mem_ready, mem_read_data    memory read handshake and data
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// RD     | load read outstanding, waiting on mem_ready
// RMW_RD | sub-word store, reading the old word
// RMW_WR | sub-word store, writing the merged word
// WR     | word store, single write cycle
// RESP   | resp_valid pulse, then back to IDLE
module dmem_req_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [WORD_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic [WORD_W-1:0]        resp_rdata,
    output logic                     resp_error,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic [$clog2(DEPTH)-1:0] mem_read_addr,
    output logic [$clog2(DEPTH)-1:0] mem_write_addr,
    output logic [WORD_W-1:0]        mem_write_data,
    input  logic                     mem_ready,
    input  logic [WORD_W-1:0]        mem_read_data
);

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_raddr_q, mem_raddr_d;
    logic [AW-1:0]     mem_waddr_q, mem_waddr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              req_error;
    logic [WORD_W-1:0] ld_data;
    logic [WORD_W-1:0] st_word;
    logic              accept;
    logic [AW-1:0]     req_word;

    // Error check looks at the live request; load/merge use the latched one.
    lsu_align u_align (
        .chk_size    (req_size),
        .chk_lane    (req_addr[1:0]),
        .chk_error   (req_error),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .rd_word     (mem_read_data),
        .wr_data     (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    assign accept   = req_valid && req_ready_q;
    assign req_word = req_addr[AW+1:2];

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = 1'b0;
        mem_raddr_d  = mem_raddr_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    lane_d       = req_addr[1:0];
                    wdata_d      = req_wdata;
                    req_ready_d  = 1'b0;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b0;
                    if (req_error) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write) begin
                        state_d     = RD;
                        mem_re_d    = 1'b1;
                        mem_raddr_d = req_word;
                    end else if (req_size == SZ_WORD) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = req_word;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d     = RMW_RD;
                        mem_re_d    = 1'b1;
                        mem_raddr_d = req_word;
                        mem_waddr_d = req_word;
                    end
                end
            end
            RD: begin
                if (mem_ready) begin
                    state_d      = RESP;
                    mem_re_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            RMW_RD: begin
                // The merged word is built straight from the read data, so
                // the write-data register doubles as the capture register.
                if (mem_ready) begin
                    state_d     = RMW_WR;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = st_word;
                end
            end
            RMW_WR, WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_re_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            size_q       <= '0;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_raddr_q  <= '0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_raddr_q  <= mem_raddr_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_error       = resp_error_q;
    assign resp_rdata       = resp_rdata_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_addr    = mem_raddr_q;
    assign mem_write_addr   = mem_waddr_q;
    assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [9:0]  mem_read_addr;
    logic [9:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_req_ctrl #(.DEPTH(1024), .ADDR_W(32)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_addr    (mem_read_addr),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_ready        (mem_ready),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with programmable read latency and a preload port.
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)                 mem[pl_addr] <= pl_data;
        else if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
        if (mem_read_enable && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    assign mem_ready     = (wait_cnt >= mem_lat);
    assign mem_read_data = mem[mem_read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: what a request should do, computed from the access rules.
    task automatic ref_op(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic err, output logic [31:0] rdata,
                          output int lat, output int rd_cyc, output int wr_cyc);
        int unsigned old, v, sh, mask;
        int          word;
        word   = int'(ad[11:2]);
        old    = ref_mem[word];
        err    = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
        rdata  = 32'h0;
        rd_cyc = 0;
        wr_cyc = 0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat    = 2 + mem_lat;
            rd_cyc = 1 + mem_lat;
            if (sz == 2'd0) begin
                sh = 8 * ad[1:0];
                v  = (old >> sh) & 32'hFF;
                if (!un && v >= 128) v = v - 256;
            end else if (sz == 2'd1) begin
                sh = 16 * ad[1];
                v  = (old >> sh) & 32'hFFFF;
                if (!un && v >= 32768) v = v - 65536;
            end else begin
                v = old;
            end
            rdata = v;
        end else if (sz == 2'd2) begin
            lat    = 2;
            wr_cyc = 1;
            ref_mem[word] = wd;
        end else begin
            lat    = 3 + mem_lat;
            rd_cyc = 1 + mem_lat;
            wr_cyc = 1;
            sh     = (sz == 2'd0) ? 8 * ad[1:0] : 16 * ad[1];
            mask   = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[word] = (old & ~mask) | ((wd << sh) & mask);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] got_rdata, output int got_lat);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_rd, e_wr;
        int          n, rd_cnt, wr_cnt, both, ready_hi, bad_addr;
        logic        done;
        logic [9:0]  word;
        word = ad[11:2];
        ref_op(wr, sz, un, ad, wd, e_err, e_rdata, e_lat, e_rd, e_wr);
        @(negedge clk);
        chk("ready_before_accept", {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = ad;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0; rd_cnt = 0; wr_cnt = 0; both = 0; ready_hi = 0; bad_addr = 0;
        done = 1'b0;
        got_rdata = 32'hX;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_read_enable)  rd_cnt++;
            if (mem_write_enable) wr_cnt++;
            if (mem_read_enable && mem_write_enable) both++;
            if (req_ready) ready_hi++;
            if (mem_read_enable && mem_read_addr !== word) bad_addr++;
            if (mem_write_enable && mem_write_addr !== word) bad_addr++;
            if (resp_valid) begin
                done = 1'b1;
                got_rdata = resp_rdata;
                chk("resp_error", {31'h0, resp_error}, {31'h0, e_err});
                chk("resp_rdata", resp_rdata, e_rdata);
            end
        end
        got_lat = n;
        chk("resp_seen", {31'h0, done}, 32'h1);
        chk("latency", n, e_lat);
        chk("read_cycles", rd_cnt, e_rd);
        chk("write_cycles", wr_cnt, e_wr);
        chk("rd_wr_overlap", both, 0);
        chk("ready_low_busy", ready_hi, 0);
        chk("mem_addr", bad_addr, 0);
        chk("mem_word", mem[word], ref_mem[word]);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        logic [1:0]  rsz;
        logic [31:0] raddr;

        rstn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        #23;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_re", {31'h0, mem_read_enable}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 32; i++) preload(i[9:0], $urandom);
        preload(10'd4, 32'h8899AABB);
        preload(10'd8, 32'h12345678);
        preload(10'd12, 32'hCAFEF00D);

        // Reset while the merged word is being written: no write must land.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h31; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l = 0;
        while (!mem_write_enable && l < 20) begin
            @(negedge clk);
            l++;
        end
        chk("rmw_reached_write", {31'h0, mem_write_enable}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_mem_we", {31'h0, mem_write_enable}, 32'h0);
        chk("midrst_mem_re", {31'h0, mem_read_enable}, 32'h0);
        chk("midrst_wdata", mem_write_data, 32'h0);
        chk("midrst_raddr", {22'h0, mem_read_addr}, 32'h0);
        chk("midrst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("postrst_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_mem_kept", mem[12], 32'hCAFEF00D);

        // Zero-latency sub-word loads.
        mem_lat = 0;
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r, l);
        chk("lb_0x13", r, 32'hFFFFFF88);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, r, l);
        chk("lbu_0x13", r, 32'h00000088);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, r, l);
        chk("lh_0x12", r, 32'hFFFF8899);

        // Latency-1 word load.
        mem_lat = 1;
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, l);
        chk("lw_0x20", r, 32'h12345678);
        chk("lw_lat1_latency", l, 3);
        mem_lat = 0;

        // Byte store via read-modify-write.
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hEE, r, l);
        chk("sb_latency", l, 3);
        chk("sb_word", mem[4], 32'h8899EEBB);

        // Misaligned requests.
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h1234, r, l);
        chk("sw_misaligned_latency", l, 1);
        do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, r, l);

        // Back-to-back store then load of the same word.
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, r, l);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, l);
        chk("b2b_lw", r, 32'hDEADBEEF);

        // Random mix over the preloaded region.
        for (int i = 0; i < 60; i++) begin
            mem_lat = $urandom_range(0, 2);
            rsz     = 2'($urandom_range(0, 3));
            raddr   = 32'($urandom_range(0, 127));
            do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                   raddr, $urandom, r, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
